systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//  Collects the skewed IEEE-754 single-precision results leaving the bottom edge of the
//  N-column MAC systolic array and de-skews them into complete rows. It buffers up to 2 rows
//  in ping-pong banks and streams each row out one word per beat on a valid/ready interface.
//  This is the read side of the array: feeders skew operands in, this block drains sums out.
// PARAMETERS
//  N  4   number of array columns (words per row), >= 2
//  W  32  word width (IEEE-754 single); data passed bit-exact, no arithmetic
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    asynchronous, active-high reset
//  col_sum    in   N*W  column results; column k at bits [k*W +: W]
//  col_vld    in   N    per-column result valid; strict skew: col_vld[k](t) == col_vld[0](t-k)
//  out_data   out  W    drained word
//  out_valid  out  1    out_data valid
//  out_ready  in   1    downstream accepts when out_valid && out_ready
//  out_last   out  1    marks column N-1 word of a row
//  ovf        out  1    sticky: a row was dropped for lack of a free bank
//  ovf_clr    in   1    clears ovf (synchronous)
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out_data=0, ovf=0; both banks free; write and read
//    bank pointers=0; drop chain=0. Reset mid-row discards all partial and buffered rows.
//  - Storage: 2 banks x N words; per bank: busy (allocated) and done (row complete) flags.
//  - Allocation: on a col_vld[0] edge, if bank[wptr] is not busy, set busy, write word 0,
//    and launch token {bank=wptr, drop=0} into an (N-1)-stage shift chain; toggle wptr.
//    If bank[wptr] is busy: set ovf, launch {drop=1}; wptr unchanged; no write.
//  - Column k>0 writes col_sum[k] into the bank carried by chain stage k when col_vld[k]=1
//    and the token drop=0; a dropped token suppresses all N writes of that row.
//  - Column N-1 write sets done for that bank. out_valid rises the cycle after (1-cycle latency
//    from the last column capture to first output beat).
//  - Drain: when bank[rptr].done, present words 0..N-1 in column order, one per accepted beat;
//    out_last=1 on word N-1. out_data/out_last hold stable while out_valid && !out_ready.
//  - On acceptance of the last word: clear busy and done of bank[rptr], toggle rptr; if the
//    other bank is done, its word 0 is presented the next cycle (no idle beat).
//  - Busy is sampled before the edge: a bank released in the same cycle col_vld[0] targets it
//    is still busy -> row dropped, ovf set.
//  - ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
//  - col_vld[k] without a matching token (skew violation) is ignored; no write occurs.
//  - Rows drain in arrival order; at most 2 rows buffered; back-to-back rows (col_vld[0] on
//    consecutive cycles) are accepted while a free bank exists.
// TESTING
//  1 N=4, one row {0x42600000(56.0),0x41200000(10.0),0x3F800000(1.0),0xC0000000(-2.0)},
//    out_ready=1 -> 4 beats in that order, out_last only on 0xC0000000, first beat 1 cycle
//    after the col 3 capture.
//  2 Two back-to-back rows, out_ready=0 until both are done, then 1 -> 8 beats, no gap
//    between rows, row order preserved, ovf=0.
//  3 Three back-to-back rows with out_ready=0 -> rows 1 and 2 buffered, row 3 dropped
//    (no writes), ovf=1. Release ready -> exactly 8 beats. Pulse ovf_clr -> ovf=0.
//  4 Last word of bank 0 accepted in the same cycle col_vld[0] targets bank 0 -> row
//    dropped, ovf=1; next row one cycle later is accepted.
//  5 out_ready toggled 1/0 each cycle during drain -> out_data and out_last stable while
//    stalled; no word lost or duplicated.
//  6 Assert rst in the middle of row capture and during drain -> out_valid=0 and ovf=0
//    immediately; a row fed after reset drains correctly from bank 0.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Drained-row output stream of the systolic result drain.
//   out_data  : drained word, column order within a row
//   out_valid : out_data is valid
//   out_ready : downstream accepts the beat when out_valid && out_ready
//   out_last  : marks the column N-1 word of a row
// The drain block uses the master modport, the downstream consumer the slave modport.
interface systolic_result_drain_if #(
  parameter int W = 32
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Systolic result drain: collects the skewed results leaving the bottom edge of an
// N-column MAC array, de-skews them into complete rows held in two ping-pong banks,
// and streams each row out one word per beat, column 0 first.
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous, active-high reset
//   col_sum  : column results, column k at [k*W +: W]
//   col_vld  : per-column valid, column k lags column 0 by k cycles
//   drain    : output stream (out_data/out_valid/out_ready/out_last)
//   ovf      : sticky, a row was dropped because no bank was free
//   ovf_clr  : synchronous clear of ovf (a same-cycle new overflow wins)
module systolic_result_drain #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*W-1:0]            col_sum,
  input  logic [N-1:0]              col_vld,
  systolic_result_drain_if.master   drain,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // A token follows each row down the skew so that column k knows which bank the
  // row was given, or that the row was dropped. tok[j] lines up with column j+1.
  typedef struct packed {
    logic vld;
    logic bank;
    logic drop;
  } token_t;

  token_t         tok [N-1];
  logic [W-1:0]   mem [2][N];
  logic [1:0]     busy;
  logic [1:0]     done;
  logic           wptr;
  logic           rptr;
  logic [IW-1:0]  ridx;

  logic           alloc;
  logic           start_drop;
  logic           accept;
  logic           release_row;
  logic [N-1:0]   wr_en;
  logic [N-1:0]   wr_bank;

  // Busy is the registered value, so a bank released this cycle still looks busy
  // to a row starting this cycle and that row is dropped.
  assign alloc       = col_vld[0] && !busy[wptr];
  assign start_drop  = col_vld[0] &&  busy[wptr];
  assign accept      = done[rptr] && drain.out_ready;
  assign release_row = accept && (ridx == LAST);

  assign drain.out_valid = done[rptr];
  assign drain.out_last  = done[rptr] && (ridx == LAST);
  assign drain.out_data  = done[rptr] ? mem[rptr][ridx] : '0;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_en      = '0;
    wr_bank    = '0;
    wr_en[0]   = alloc;
    wr_bank[0] = wptr;
    for (int k = 1; k < N; k++) begin
      // A column valid with no live token is a skew violation and is ignored.
      wr_en[k]   = col_vld[k] && tok[k-1].vld && !tok[k-1].drop;
      wr_bank[k] = tok[k-1].bank;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      done <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      ridx <= '0;
      ovf  <= 1'b0;
      for (int j = 0; j < N - 1; j++) begin
        tok[j] <= '0;
      end
    end else begin
      tok[0].vld  <= col_vld[0];
      tok[0].bank <= wptr;
      tok[0].drop <= start_drop;
      for (int j = 1; j < N - 1; j++) begin
        tok[j] <= tok[j-1];
      end

      if (alloc) begin
        wptr       <= ~wptr;
        busy[wptr] <= 1'b1;
      end

      if (start_drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

      if (accept) begin
        ridx <= release_row ? '0 : ridx + IW'(1);
      end

      // The released bank is busy and the allocated bank is free, so these never
      // touch the same bank in one cycle.
      if (release_row) begin
        rptr       <= ~rptr;
        busy[rptr] <= 1'b0;
        done[rptr] <= 1'b0;
      end

      if (wr_en[N-1]) begin
        done[wr_bank[N-1]] <= 1'b1;
      end
    end
  end

  // NOTE: the row storage has no reset; a bank is only read once its done flag is
  // set, and done is cleared by reset, so stale contents are never visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (wr_en[k]) begin
        mem[wr_bank[k]][k] <= col_sum[k*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (N=4, W=32): a table-driven single-row
// timing test followed by hand-written multi-row, overflow, stall and reset sequences.
module tb_systolic_result_drain;

  localparam int N = 4;
  localparam int W = 32;

  typedef logic [W-1:0]   word_t;
  typedef logic [N*W-1:0] row_t;

  typedef struct {
    logic  v;
    logic  rdy;
    logic  ev;
    word_t ed;
    logic  el;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] col_sum;
  logic [N-1:0]   col_vld;
  logic           ovf;
  logic           ovf_clr;

  systolic_result_drain_if #(.W(W)) drain_if ();

  systolic_result_drain #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .col_sum (col_sum),
    .col_vld (col_vld),
    .drain   (drain_if),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    step_no  = 0;
  int    acc_cnt  = 0;
  int    first_acc;
  int    last_acc;
  logic  model_on = 1'b0;

  logic  hist_v   [N];
  row_t  hist_row [N];

  word_t exp_q[$];
  logic  last_q[$];

  logic  obs_valid;
  word_t obs_data;
  logic  obs_last;
  logic  obs_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, step_no);
    end
  endtask

  function automatic row_t mk_row(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push_row(input row_t r);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(r[k*W +: W]);
      last_q.push_back(k == N - 1);
    end
  endtask

  // Scoreboard: every presented beat must match the head of the expected queue,
  // including while stalled; the head is popped only when the beat is accepted.
  task automatic observe();
    obs_valid = drain_if.out_valid;
    obs_data  = drain_if.out_data;
    obs_last  = drain_if.out_last;
    obs_ovf   = ovf;
    if (model_on && obs_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_beat: got data %h with nothing expected (step %0d)", obs_data, step_no);
      end else begin
        check("beat_data", obs_data, exp_q[0]);
        check("beat_last", obs_last, last_q[0]);
        if (drain_if.out_ready) begin
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
          if (acc_cnt == 0) first_acc = step_no;
          last_acc = step_no;
          acc_cnt++;
        end
      end
    end
  endtask

  // One clock cycle: model the array skew (column k sees the row started k cycles
  // ago), drive inputs just after the rising edge, sample on the falling edge.
  task automatic step(input logic v, input row_t row, input logic rdy, input logic clr);
    for (int k = N - 1; k > 0; k--) begin
      hist_v[k]   = hist_v[k-1];
      hist_row[k] = hist_row[k-1];
    end
    hist_v[0]   = v;
    hist_row[0] = row;
    for (int k = 0; k < N; k++) begin
      col_vld[k]          = hist_v[k];
      col_sum[k*W +: W]   = hist_row[k][k*W +: W];
    end
    drain_if.out_ready = rdy;
    ovf_clr            = clr;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check({tag, "_valid"}, drain_if.out_valid, 1'b0);
    check({tag, "_last"},  drain_if.out_last,  1'b0);
    check({tag, "_data"},  drain_if.out_data,  '0);
    check({tag, "_ovf"},   ovf,                1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    row_t r1, ra, rb, rc, rd, re, rg, rh;

    r1 = mk_row(32'h42600000, 32'h41200000, 32'h3F800000, 32'hC0000000);
    ra = mk_row(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    rb = mk_row(32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000);
    rc = mk_row(32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001);
    rd = mk_row(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0);
    re = mk_row(32'hAAAA5555, 32'h5555AAAA, 32'h00FF00FF, 32'hFF00FF00);
    rg = mk_row(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    rh = mk_row(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);

    // Single row, ready held high: first beat one cycle after the column 3 capture.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h42600000, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h41200000, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h3F800000, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'hC0000000, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};

    for (int k = 0; k < N; k++) begin
      hist_v[k]   = 1'b0;
      hist_row[k] = '0;
    end
    col_vld            = '0;
    col_sum            = '0;
    ovf_clr            = 1'b0;
    drain_if.out_ready = 1'b0;
    do_reset("reset");

    // Test 1: table-driven single row.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, r1, tbl[i].rdy, 1'b0);
      check("t1_valid", obs_valid, tbl[i].ev);
      check("t1_ovf",   obs_ovf,   1'b0);
      if (tbl[i].ev) begin
        check("t1_data", obs_data, tbl[i].ed);
        check("t1_last", obs_last, tbl[i].el);
      end
    end

    // Test 2: two back-to-back rows held, then drained without a gap.
    model_on = 1'b1;
    acc_cnt  = 0;
    push_row(ra);
    push_row(rb);
    step(1'b1, ra, 1'b0, 1'b0);
    step(1'b1, rb, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    check("t2_held_valid", obs_valid, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t2_beats",  acc_cnt, 8);
    check("t2_no_gap", last_acc - first_acc, 7);
    check("t2_ovf",    obs_ovf, 1'b0);

    // Test 3: third back-to-back row dropped, exactly 8 beats, then ovf_clr.
    acc_cnt = 0;
    push_row(rb);
    push_row(ra);
    step(1'b1, rb, 1'b0, 1'b0);
    step(1'b1, ra, 1'b0, 1'b0);
    step(1'b1, rc, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    check("t3_ovf_set", obs_ovf, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    check("t3_beats",     acc_cnt,   8);
    check("t3_idle",      obs_valid, 1'b0);
    check("t3_ovf_still", obs_ovf,   1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t3_ovf_clr", obs_ovf, 1'b0);

    // Test 4: from reset, bank 0 released in the cycle a new row targets it.
    do_reset("t4_reset");
    acc_cnt = 0;
    push_row(ra);
    push_row(rb);
    push_row(rd);
    step(1'b1, ra, 1'b0, 1'b0);
    step(1'b1, rb, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, rc, 1'b1, 1'b0);
    check("t4_ovf_before", obs_ovf, 1'b0);
    step(1'b1, rd, 1'b1, 1'b0);
    check("t4_ovf_set", obs_ovf, 1'b1);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t4_beats",  acc_cnt, 12);
    check("t4_no_gap", last_acc - first_acc, 11);

    // Test 5: ready toggling during drain; the scoreboard checks every stalled beat.
    step(1'b0, '0, 1'b0, 1'b1);
    acc_cnt = 0;
    push_row(re);
    step(1'b1, re, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, (i % 2) == 0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t5_beats", acc_cnt,   4);
    check("t5_idle",  obs_valid, 1'b0);
    check("t5_ovf",   obs_ovf,   1'b0);

    // Test 6: reset while rows are buffered and one is mid-capture, then mid-drain.
    model_on = 1'b0;
    step(1'b1, ra, 1'b0, 1'b0);
    step(1'b1, rb, 1'b0, 1'b0);
    step(1'b1, rc, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t6_ovf_before", obs_ovf, 1'b1);
    check("t6_valid_before", drain_if.out_valid, 1'b1);
    do_reset("t6_rst_capture");
    // Leftover skewed columns of the interrupted rows arrive with no token and are ignored.
    model_on = 1'b1;
    acc_cnt  = 0;
    push_row(rg);
    step(1'b1, rg, 1'b1, 1'b0);
    for (int i = 0; i < 20 && acc_cnt < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t6_partial", acc_cnt, 2);
    do_reset("t6_rst_drain");
    acc_cnt = 0;
    push_row(rh);
    step(1'b1, rh, 1'b1, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t6_beats", acc_cnt,   4);
    check("t6_idle",  obs_valid, 1'b0);
    check("t6_ovf",   obs_ovf,   1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
